ibex_rf_write_buffer: RTL and testbench
=======================================

Name: ibex_rf_write_buffer

Overview:
- Write-side buffer placed directly upstream of the register file's single write port (waddr/wdata/we).
- Absorbs writeback requests while the register file is busy (an L2 SRAM access in progress, reg_stall asserted) and drains them in order once the port is free.
- Forwards pending (not yet written) data to ID-stage operand reads, so a buffered write is never lost or read stale.
- Gives back-pressure to writeback when full.

Parameters:
- DataWidth, 32, width of register data.
- Depth, 4, number of buffer entries; must be a power of two, 2..8.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- wb_we_i  input  1  writeback write request
- wb_waddr_i  input  5  destination register address
- wb_wdata_i  input  DataWidth  write data
- wb_ready_o  output  1  buffer can accept a request this cycle
- rf_we_o  output  1  write request to register file (head entry valid)
- rf_waddr_o  output  5  head entry address
- rf_wdata_o  output  DataWidth  head entry data
- rf_ready_i  input  1  register file accepts the write this cycle (low while stalled)
- raddr_a_i  input  5  ID read address, port A
- raddr_b_i  input  5  ID read address, port B
- fwd_a_hit_o  output  1  port A address matches a pending entry
- fwd_a_data_o  output  DataWidth  forwarded data, port A
- fwd_b_hit_o  output  1  port B address matches a pending entry
- fwd_b_data_o  output  DataWidth  forwarded data, port B
- empty_o  output  1  no pending entries
- count_o  output  $clog2(Depth)+1  pending entry count

Behaviour:
- Reset (async, rst_ni low):
  - head/tail pointers, count and all entry valid bits clear. Entry data is not reset.
  - Outputs during reset: wb_ready_o=1, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, fwd hits=0, fwd data=0, empty_o=1, count_o=0.
  - Reset mid-drain discards all pending entries. No partial write is issued.
- Storage: circular FIFO of Depth entries {addr[4:0], data}. Tail advances on enqueue, head on dequeue; both wrap modulo Depth. count is 0..Depth inclusive.
- Enqueue: occurs when wb_we_i && wb_ready_o at a clock edge.
  - Writes with wb_waddr_i==0 are accepted and discarded: no enqueue, count unchanged.
  - wb_ready_o = (count != Depth). It does not depend on rf_ready_i, so there is no combinational path rf_ready_i -> wb_ready_o.
  - When full, wb_ready_o=0 even if a dequeue happens the same cycle.
  - wb_we_i while not ready is ignored; the requester must hold it.
- Dequeue: rf_we_o = !empty. rf_waddr_o/rf_wdata_o show the head entry; they are 0 when empty.
  - A transfer occurs when rf_we_o && rf_ready_i. Head advances and count decrements.
  - Outputs are held stable while rf_ready_i=0.
- Latency: minimum one cycle. A write accepted at edge N appears on rf_we_o after edge N; there is no combinational input-to-RF bypass.
- Simultaneous enqueue and dequeue (count between 1 and Depth-1): count unchanged, both pointers advance.
- Empty with enqueue: count becomes 1, and the entry is presented next cycle.
- Forwarding (combinational on raddr and stored entries only):
  - fwd_x_hit_o=1 if any valid entry has addr==raddr_x_i and raddr_x_i!=0.
  - fwd_x_data_o is the data of the youngest matching entry (closest to tail); it is 0 when there is no hit.
  - The same-cycle wb_* input is not forwarded.
  - An entry being dequeued this cycle still forwards this cycle.
- Ordering: writes retire to the register file in acceptance order. Duplicate addresses are kept as separate entries; there is no coalescing.
- empty_o = (count==0). count_o = count.

Test Plan:
- Reset then idle -> wb_ready_o=1, rf_we_o=0, empty_o=1, count_o=0, fwd hits=0.
- Write x5=0x11111111 with rf_ready_i=1 -> rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x11111111 one cycle later; transfer occurs; empty_o=1 the following cycle.
- rf_ready_i=0; write x1..x4 with data 0xA1..0xA4 -> count_o=4, wb_ready_o=0; a fifth write, x6, is held off. Raise rf_ready_i -> drain order x1,x2,x3,x4. wb_ready_o rises the cycle after the first transfer; x6 is then accepted.
- rf_ready_i=0; write x7=0xAAAA0000 then x7=0xBBBB0000; raddr_a_i=7, raddr_b_i=0 -> fwd_a_hit_o=1, fwd_a_data_o=0xBBBB0000, fwd_b_hit_o=0. After the full drain the RF receives 0xAAAA0000 then 0xBBBB0000.
- Write x0=0xDEADBEEF -> accepted (wb_ready_o=1), count_o stays 0, rf_we_o never asserts.
- Fill to 3 entries with rf_ready_i=0, then assert rst_ni=0 mid-cycle -> immediately count_o=0, rf_we_o=0, empty_o=1; no writes reach the RF after release.

Source files
------------

// File: rtl/ibex_rf_write_buffer.sv
// Purpose: in-order write buffer in front of the register file write port, with operand forwarding.
// Latency: one cycle minimum from wb_* acceptance to rf_we_o; forwarding is combinational.
// Backpressure: wb_ready_o drops when all Depth entries are pending; rf_ready_i low holds the head.
module ibex_rf_write_buffer #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wb_we_i,
    input  logic [4:0]                 wb_waddr_i,
    input  logic [DataWidth-1:0]       wb_wdata_i,
    output logic                       wb_ready_o,
    output logic                       rf_we_o,
    output logic [4:0]                 rf_waddr_o,
    output logic [DataWidth-1:0]       rf_wdata_o,
    input  logic                       rf_ready_i,
    input  logic [4:0]                 raddr_a_i,
    input  logic [4:0]                 raddr_b_i,
    output logic                       fwd_a_hit_o,
    output logic [DataWidth-1:0]       fwd_a_data_o,
    output logic                       fwd_b_hit_o,
    output logic [DataWidth-1:0]       fwd_b_data_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [4:0]           addr_q  [Depth];
    logic [DataWidth-1:0] data_q  [Depth];
    logic [Depth-1:0]     valid_q, valid_d;
    logic [PtrW-1:0]      head_q, head_d;
    logic [PtrW-1:0]      tail_q, tail_d;
    logic [CntW-1:0]      count_q, count_d;

    logic                 enq, deq;
    logic [PtrW-1:0]      age_idx [Depth];

    // Ready depends only on occupancy, never on rf_ready_i, so a full buffer
    // stays not-ready even in a cycle where the head drains.
    assign wb_ready_o = (count_q != CntW'(Depth));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

    // Writes to x0 are acknowledged but never stored.
    assign enq = wb_we_i && wb_ready_o && (wb_waddr_i != 5'd0);
    assign deq = rf_we_o && rf_ready_i;

    assign rf_we_o    = !empty_o;
    assign rf_waddr_o = empty_o ? 5'd0 : addr_q[head_q];
    assign rf_wdata_o = empty_o ? '0   : data_q[head_q];

    // Next-state for pointers, occupancy and per-entry valid bits.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (enq) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        if (deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register; entries are discarded by clearing valid/count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload storage; contents are qualified by valid_q so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_q[tail_q] <= wb_waddr_i;
            data_q[tail_q] <= wb_wdata_i;
        end
    end

    // Entries ordered oldest-first starting at the head pointer.
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            age_idx[i] = head_q + PtrW'(i);
        end
    end

    // Forwarding scans oldest to youngest so the last match (youngest) wins;
    // only stored entries participate, never the same-cycle wb_* request.
    always_comb begin
        fwd_a_hit_o  = 1'b0;
        fwd_a_data_o = '0;
        fwd_b_hit_o  = 1'b0;
        fwd_b_data_o = '0;
        for (int i = 0; i < Depth; i++) begin
            if (valid_q[age_idx[i]] && (raddr_a_i != 5'd0) &&
                (addr_q[age_idx[i]] == raddr_a_i)) begin
                fwd_a_hit_o  = 1'b1;
                fwd_a_data_o = data_q[age_idx[i]];
            end
            if (valid_q[age_idx[i]] && (raddr_b_i != 5'd0) &&
                (addr_q[age_idx[i]] == raddr_b_i)) begin
                fwd_b_hit_o  = 1'b1;
                fwd_b_data_o = data_q[age_idx[i]];
            end
        end
    end

endmodule

// File: tb/tb_ibex_rf_write_buffer.sv
module tb_ibex_rf_write_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [4:0]  wb_waddr_i = '0;
    logic [31:0] wb_wdata_i = '0;
    logic        wb_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        rf_ready_i = 1'b0;
    logic [4:0]  raddr_a_i = '0;
    logic [4:0]  raddr_b_i = '0;
    logic        fwd_a_hit_o;
    logic [31:0] fwd_a_data_o;
    logic        fwd_b_hit_o;
    logic [31:0] fwd_b_data_o;
    logic        empty_o;
    logic [2:0]  count_o;

    int total = 0;
    int bad   = 0;

    // Register-file side log of completed writes: {addr, data}.
    logic [36:0] rf_log[$];

    ibex_rf_write_buffer #(.DataWidth(32), .Depth(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .wb_we_i      (wb_we_i),
        .wb_waddr_i   (wb_waddr_i),
        .wb_wdata_i   (wb_wdata_i),
        .wb_ready_o   (wb_ready_o),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .rf_ready_i   (rf_ready_i),
        .raddr_a_i    (raddr_a_i),
        .raddr_b_i    (raddr_b_i),
        .fwd_a_hit_o  (fwd_a_hit_o),
        .fwd_a_data_o (fwd_a_data_o),
        .fwd_b_hit_o  (fwd_b_hit_o),
        .fwd_b_data_o (fwd_b_data_o),
        .empty_o      (empty_o),
        .count_o      (count_o)
    );

    always #5 clk_i = ~clk_i;

    // Capture each accepted register-file write at the clock edge.
    always @(posedge clk_i) begin
        if (rst_ni && rf_we_o && rf_ready_i)
            rf_log.push_back({rf_waddr_o, rf_wdata_o});
    end

    task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle write request; called and returns at a falling edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_we_i    = 1'b1;
        wb_waddr_i = a;
        wb_wdata_i = d;
        @(negedge clk_i);
        wb_we_i    = 1'b0;
    endtask

    // Drain with a bounded wait; a timeout shows up as a failed check.
    task automatic drain(input string tag);
        int n = 0;
        rf_ready_i = 1'b1;
        while (!empty_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk(tag, empty_o, 1);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_ready", wb_ready_o, 1);
        chk("rst_rf_we", rf_we_o, 0);
        chk("rst_rf_waddr", rf_waddr_o, 0);
        chk("rst_rf_wdata", rf_wdata_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_count", count_o, 0);
        chk("rst_hit_a", fwd_a_hit_o, 0);
        chk("rst_hit_b", fwd_b_hit_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_empty", empty_o, 1);
        chk("idle_rf_we", rf_we_o, 0);

        // Single write passes straight through
        rf_ready_i = 1'b1;
        chk("t2_ready", wb_ready_o, 1);
        wb_we_i = 1'b1; wb_waddr_i = 5'd5; wb_wdata_i = 32'h1111_1111;
        chk("t2_no_bypass", rf_we_o, 0);
        @(negedge clk_i);
        wb_we_i = 1'b0;
        chk("t2_rf_we", rf_we_o, 1);
        chk("t2_rf_waddr", rf_waddr_o, 5);
        chk("t2_rf_wdata", rf_wdata_o, 32'h1111_1111);
        chk("t2_count", count_o, 1);
        @(negedge clk_i);
        chk("t2_empty", empty_o, 1);
        chk("t2_rf_we_off", rf_we_o, 0);
        chk("t2_log_n", rf_log.size(), 1);
        if (rf_log.size() >= 1) chk("t2_log0", rf_log[0], {5'd5, 32'h1111_1111});
        rf_log.delete();

        // Fill while stalled, hold off a fifth write, then drain in order
        rf_ready_i = 1'b0;
        wr(5'd1, 32'hA1);
        wr(5'd2, 32'hA2);
        wr(5'd3, 32'hA3);
        wr(5'd4, 32'hA4);
        chk("t3_count_full", count_o, 4);
        chk("t3_ready_full", wb_ready_o, 0);
        chk("t3_head_addr", rf_waddr_o, 1);
        wb_we_i = 1'b1; wb_waddr_i = 5'd6; wb_wdata_i = 32'hA6;
        @(negedge clk_i);
        chk("t3_held_count", count_o, 4);
        chk("t3_held_ready", wb_ready_o, 0);
        rf_ready_i = 1'b1;
        chk("t3_ready_same_cycle", wb_ready_o, 0);
        @(negedge clk_i);
        chk("t3_after_first_count", count_o, 3);
        chk("t3_after_first_ready", wb_ready_o, 1);
        chk("t3_head2", rf_waddr_o, 2);
        @(negedge clk_i);
        wb_we_i = 1'b0;
        chk("t3_simul_count", count_o, 3);
        drain("t3_drain");
        chk("t3_log_n", rf_log.size(), 5);
        if (rf_log.size() == 5) begin
            chk("t3_log0", rf_log[0], {5'd1, 32'hA1});
            chk("t3_log1", rf_log[1], {5'd2, 32'hA2});
            chk("t3_log2", rf_log[2], {5'd3, 32'hA3});
            chk("t3_log3", rf_log[3], {5'd4, 32'hA4});
            chk("t3_log4", rf_log[4], {5'd6, 32'hA6});
        end
        rf_log.delete();

        // Forwarding picks the youngest duplicate; duplicates both retire
        rf_ready_i = 1'b0;
        wr(5'd7, 32'hAAAA_0000);
        wr(5'd7, 32'hBBBB_0000);
        raddr_a_i = 5'd7; raddr_b_i = 5'd0;
        #1;
        chk("t4_hit_a", fwd_a_hit_o, 1);
        chk("t4_data_a", fwd_a_data_o, 32'hBBBB_0000);
        chk("t4_hit_b_x0", fwd_b_hit_o, 0);
        chk("t4_data_b_x0", fwd_b_data_o, 0);
        raddr_b_i = 5'd5;
        #1;
        chk("t4_hit_b_miss", fwd_b_hit_o, 0);
        raddr_b_i = 5'd7;
        rf_ready_i = 1'b1;
        #1;
        chk("t4_hit_b_deq", fwd_b_hit_o, 1);
        chk("t4_data_b_deq", fwd_b_data_o, 32'hBBBB_0000);
        @(negedge clk_i);
        chk("t4_one_left_data", fwd_a_data_o, 32'hBBBB_0000);
        drain("t4_drain");
        chk("t4_hit_a_gone", fwd_a_hit_o, 0);
        chk("t4_log_n", rf_log.size(), 2);
        if (rf_log.size() == 2) begin
            chk("t4_log0", rf_log[0], {5'd7, 32'hAAAA_0000});
            chk("t4_log1", rf_log[1], {5'd7, 32'hBBBB_0000});
        end
        rf_log.delete();
        raddr_a_i = 5'd0; raddr_b_i = 5'd0;

        // Writes to x0 are accepted and dropped
        wb_we_i = 1'b1; wb_waddr_i = 5'd0; wb_wdata_i = 32'hDEAD_BEEF;
        chk("t5_ready", wb_ready_o, 1);
        @(negedge clk_i);
        wb_we_i = 1'b0;
        chk("t5_count", count_o, 0);
        chk("t5_rf_we", rf_we_o, 0);
        @(negedge clk_i);
        chk("t5_log_n", rf_log.size(), 0);

        // Reset in the middle of a stalled fill discards everything
        rf_ready_i = 1'b0;
        wr(5'd8, 32'hC8);
        wr(5'd9, 32'hC9);
        wr(5'd10, 32'hCA);
        chk("t6_count3", count_o, 3);
        raddr_a_i = 5'd8;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_count", count_o, 0);
        chk("t6_rst_rf_we", rf_we_o, 0);
        chk("t6_rst_empty", empty_o, 1);
        chk("t6_rst_ready", wb_ready_o, 1);
        chk("t6_rst_hit_a", fwd_a_hit_o, 0);
        chk("t6_rst_data_a", fwd_a_data_o, 0);
        chk("t6_rst_wdata", rf_wdata_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        rf_ready_i = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("t6_post_log_n", rf_log.size(), 0);
        chk("t6_post_rf_we", rf_we_o, 0);
        chk("t6_post_count", count_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
